// File: rtl/irq_encoder_16x4.sv
// Registered 16-to-4 priority encoder with falling-edge request capture and a
// valid/ack handshake. R[0] has the highest priority.
module irq_encoder_16x4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        E,
    input  logic [15:0] R,
    input  logic        ack,
    output logic [3:0]  Y,
    output logic        V,
    output logic        OVF
);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e      state_q;
    logic [15:0] prev_q;
    logic [15:0] pending_q;
    logic [15:0] fall;
    logic [15:0] clr;
    logic [15:0] pend_eff;
    logic [3:0]  sel;

    always_comb begin
        fall = prev_q & ~R;
        clr  = '0;
        if (ack && V) begin
            clr[Y] = 1'b1;
        end
        // The bit being acked this cycle must not be re-selected.
        pend_eff = pending_q & ~clr;
        sel      = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (pend_eff[i]) begin
                sel = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            prev_q    <= 16'hFFFF;
            pending_q <= '0;
            Y         <= 4'h0;
            V         <= 1'b0;
            OVF       <= 1'b0;
        end else begin
            prev_q    <= R;
            // Set wins over a same-cycle clear.
            pending_q <= fall | (pending_q & ~clr);
            if (|(fall & pending_q & ~clr)) begin
                OVF <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (!E && (|pending_q)) begin
                        Y       <= sel;
                        V       <= 1'b1;
                        state_q <= StGrant;
                    end
                end
                StGrant: begin
                    if (E) begin
                        V       <= 1'b0;
                        state_q <= StIdle;
                    end else if (ack) begin
                        if (|pend_eff) begin
                            Y <= sel;
                        end else begin
                            V       <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    V       <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_encoder_16x4.sv
// Bench for irq_encoder_16x4: directed scenarios plus random traffic, each cycle
// compared against a behavioural model of the request/grant rules.
module tb_irq_encoder_16x4;

    logic        clk;
    logic        rst_n;
    logic        E;
    logic [15:0] R;
    logic        ack;
    logic [3:0]  Y;
    logic        V;
    logic        OVF;

    int n_checks;
    int n_errors;

    // Model state
    bit m_pend [16];
    bit m_prev [16];
    int m_y;
    bit m_v;
    bit m_ovf;

    irq_encoder_16x4 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .E    (E),
        .R    (R),
        .ack  (ack),
        .Y    (Y),
        .V    (V),
        .OVF  (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one edge using the current inputs, clock the DUT, compare.
    task automatic step();
        bit clr [16];
        bit fall [16];
        int first_eff;
        int first_pend;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                m_pend[i] = 0;
                m_prev[i] = 1;
            end
            m_y   = 0;
            m_v   = 0;
            m_ovf = 0;
        end else begin
            first_eff  = -1;
            first_pend = -1;
            for (int i = 0; i < 16; i++) begin
                clr[i]  = ack && m_v && (m_y == i);
                fall[i] = m_prev[i] && !R[i];
                if (fall[i] && m_pend[i] && !clr[i]) m_ovf = 1;
                if (m_pend[i] && first_pend < 0) first_pend = i;
                if (m_pend[i] && !clr[i] && first_eff < 0) first_eff = i;
            end
            if (!m_v) begin
                if (!E && first_pend >= 0) begin
                    m_y = first_pend;
                    m_v = 1;
                end
            end else if (E) begin
                m_v = 0;
            end else if (ack) begin
                if (first_eff >= 0) m_y = first_eff;
                else m_v = 0;
            end
            for (int i = 0; i < 16; i++) begin
                m_pend[i] = fall[i] || (m_pend[i] && !clr[i]);
                m_prev[i] = R[i];
            end
        end
        @(posedge clk);
        #1;
        check("Y", int'(Y), m_y);
        check("V", int'(V), int'(m_v));
        check("OVF", int'(OVF), int'(m_ovf));
    endtask

    task automatic idle_inputs();
        R   = 16'hFFFF;
        ack = 1'b0;
        E   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        idle_inputs();
        step();
        step();
        check("reset_V", int'(V), 0);
        check("reset_Y", int'(Y), 0);
        check("reset_OVF", int'(OVF), 0);
        rst_n = 1'b1;

        // Single pulse on line 5: valid two clocks after the fall
        R = ~16'(1 << 5);
        step();
        check("lat_V_early", int'(V), 0);
        R = 16'hFFFF;
        step();
        check("s1_V", int'(V), 1);
        check("s1_Y", int'(Y), 5);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("s1_ack_V", int'(V), 0);

        // Simultaneous 3 and 9, back-to-back grants; line 1 arrives while 9 is held
        R = ~16'((1 << 3) | (1 << 9));
        step();
        R = 16'hFFFF;
        step();
        check("s2_Y3", int'(Y), 3);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("s2_Y9", int'(Y), 9);
        check("s2_V9", int'(V), 1);
        R = ~16'(1 << 1);
        step();
        R = 16'hFFFF;
        step();
        check("s3_hold9", int'(Y), 9);
        ack = 1'b1;
        step();
        check("s3_Y1", int'(Y), 1);
        step();
        ack = 1'b0;
        check("s3_done", int'(V), 0);

        // Double fall on 7 before ack -> overflow, single grant
        R = ~16'(1 << 7);
        step();
        R = 16'hFFFF;
        step();
        R = ~16'(1 << 7);
        step();
        R = 16'hFFFF;
        check("s4_ovf", int'(OVF), 1);
        check("s4_Y7", int'(Y), 7);
        ack = 1'b1;
        step();
        step();
        ack = 1'b0;
        check("s4_single", int'(V), 0);

        // Second fall coinciding with ack: re-grant, no overflow
        do_reset();
        R = ~16'(1 << 7);
        step();
        R = 16'hFFFF;
        step();
        R   = ~16'(1 << 7);
        ack = 1'b1;
        step();
        R   = 16'hFFFF;
        ack = 1'b0;
        check("s4b_ovf", int'(OVF), 0);
        step();
        check("s4b_regrant", int'(Y), 7);
        check("s4b_V", int'(V), 1);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // Disabled output side keeps the request
        E = 1'b1;
        R = ~16'(1 << 12);
        step();
        R = 16'hFFFF;
        step();
        step();
        check("s5_disabled", int'(V), 0);
        E = 1'b0;
        step();
        check("s5_V", int'(V), 1);
        check("s5_Y", int'(Y), 12);
        E = 1'b1;
        step();
        check("s5_drop", int'(V), 0);
        E = 1'b0;
        step();
        check("s5_retained", int'(Y), 12);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // Line 0 held low across reset release, then reset mid-grant
        R     = ~16'h0001;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        check("s6_Y0", int'(Y), 0);
        check("s6_V", int'(V), 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        check("s6_norepeat", int'(V), 0);
        R = 16'hFFFF;
        R = ~16'((1 << 2) | (1 << 4));
        step();
        R = 16'hFFFF;
        step();
        do_reset();
        check("s6_rst_V", int'(V), 0);
        step();
        check("s6_rst_pend", int'(V), 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] r;
            r = 16'hFFFF;
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(0, 11) == 0) r[b] = 1'b0;
            end
            R     = r;
            ack   = ($urandom_range(0, 2) == 0);
            E     = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
